// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability counter.
// Output level changes only after the input holds a new value long enough.
module debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bouncy,
    output logic debounced,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bouncy;
            s2 <= s1;
        end
    end

    // A single agreeing clock restarts the count, so only unbroken runs pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == debounced) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt       <= '0;
                debounced <= s2;
                rise      <= s2;
                fall      <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce at STABLE_CYCLES = 4, 1 and 7.
// All instances share clock, reset and input; each is checked at its own latency.
module tb_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bouncy = 1'b0;

    logic deb4, rise4, fall4;
    logic deb1, rise1, fall1;
    logic deb7, rise7, fall7;

    int n_assert = 0;
    int n_fail   = 0;

    logic pat [0:63];

    always #10 clk = ~clk;

    debounce #(.STABLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bouncy(bouncy),
        .debounced(deb4), .rise(rise4), .fall(fall4)
    );

    debounce #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bouncy(bouncy),
        .debounced(deb1), .rise(rise1), .fall(fall1)
    );

    debounce #(.STABLE_CYCLES(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .bouncy(bouncy),
        .debounced(deb7), .rise(rise7), .fall(fall7)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic pv(input int i);
        return (i < 0) ? 1'b0 : pat[i];
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_deb4", deb4, 1'b0);
        chk("rst_rise4", rise4, 1'b0);
        chk("rst_fall4", fall4, 1'b0);
        chk("rst_deb1", deb1, 1'b0);
        chk("rst_deb7", deb7, 1'b0);
        rst_n = 1'b1;

        // Idle low for 20 clocks
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_deb4[%0d]", i), deb4, 1'b0);
            chk($sformatf("idle_rise4[%0d]", i), rise4, 1'b0);
            chk($sformatf("idle_fall4[%0d]", i), fall4, 1'b0);
        end

        // Square wave, 5 clocks per phase
        for (int i = 0; i < 40; i++) pat[i] = ((i / 5) % 2) == 0;
        for (int i = 0; i < 40; i++) begin
            bouncy = pat[i];
            @(negedge clk);
            chk($sformatf("sq_deb4[%0d]", i), deb4, pv(i - 5));
            chk($sformatf("sq_rise4[%0d]", i), rise4, pv(i - 5) & ~pv(i - 6));
            chk($sformatf("sq_fall4[%0d]", i), fall4, ~pv(i - 5) & pv(i - 6));
            chk($sformatf("sq_deb1[%0d]", i), deb1, pv(i - 2));
            chk($sformatf("sq_deb7[%0d]", i), deb7, 1'b0);
        end
        bouncy = 1'b0;
        repeat (12) @(negedge clk);
        chk("sq_settle_deb4", deb4, 1'b0);

        // Step 0->1 held: latency 2+N edges for each instance
        bouncy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("up_deb4[%0d]", k), deb4, k >= 6);
            chk($sformatf("up_rise4[%0d]", k), rise4, k == 6);
            chk($sformatf("up_fall4[%0d]", k), fall4, 1'b0);
            chk($sformatf("up_deb1[%0d]", k), deb1, k >= 3);
            chk($sformatf("up_rise1[%0d]", k), rise1, k == 3);
            chk($sformatf("up_deb7[%0d]", k), deb7, k >= 9);
            chk($sformatf("up_rise7[%0d]", k), rise7, k == 9);
        end

        // Step 1->0 held
        bouncy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("dn_deb4[%0d]", k), deb4, k < 6);
            chk($sformatf("dn_fall4[%0d]", k), fall4, k == 6);
            chk($sformatf("dn_rise4[%0d]", k), rise4, 1'b0);
            chk($sformatf("dn_deb1[%0d]", k), deb1, k < 3);
            chk($sformatf("dn_fall1[%0d]", k), fall1, k == 3);
            chk($sformatf("dn_deb7[%0d]", k), deb7, k < 9);
            chk($sformatf("dn_fall7[%0d]", k), fall7, k == 9);
        end

        // Glitches of 1, 2, 3 clocks, then held high from step 12
        for (int i = 0; i < 20; i++) pat[i] = 1'b1;
        pat[1] = 1'b0; pat[2] = 1'b0;
        pat[5] = 1'b0; pat[6] = 1'b0;
        pat[10] = 1'b0; pat[11] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bouncy = pat[i];
            @(negedge clk);
            chk($sformatf("gl_deb4[%0d]", i), deb4, i >= 17);
            chk($sformatf("gl_rise4[%0d]", i), rise4, i == 17);
            chk($sformatf("gl_fall4[%0d]", i), fall4, 1'b0);
            chk($sformatf("gl_deb1[%0d]", i), deb1, pv(i - 2));
            chk($sformatf("gl_rise1[%0d]", i), rise1, pv(i - 2) & ~pv(i - 3));
            chk($sformatf("gl_deb7[%0d]", i), deb7, 1'b0);
        end
        repeat (6) @(negedge clk);
        chk("gl_settle_deb7", deb7, 1'b1);

        // Low glitch of 6 clocks: filtered by N=7, passed by N=4
        for (int i = 0; i < 16; i++) begin
            bouncy = (i >= 6);
            @(negedge clk);
            chk($sformatf("g6_deb7[%0d]", i), deb7, 1'b1);
            chk($sformatf("g6_fall7[%0d]", i), fall7, 1'b0);
            chk($sformatf("g6_deb4[%0d]", i), deb4, !(i >= 5 && i < 11));
            chk($sformatf("g6_fall4[%0d]", i), fall4, i == 5);
            chk($sformatf("g6_rise4[%0d]", i), rise4, i == 11);
        end

        // Reset pulse while counting toward 0
        bouncy = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_deb4", deb4, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_deb4", deb4, 1'b0);
        chk("arst_rise4", rise4, 1'b0);
        chk("arst_fall4", fall4, 1'b0);
        chk("arst_deb7", deb7, 1'b0);
        bouncy = 1'b1;
        @(negedge clk);
        chk("arst_hold_deb4", deb4, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("rel_deb4[%0d]", k), deb4, k >= 6);
            chk($sformatf("rel_rise4[%0d]", k), rise4, k == 6);
            chk($sformatf("rel_fall4[%0d]", k), fall4, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
